// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: WIDTH-bit add/sub built from 4-bit CLA groups, one group resolved per
// pipeline stage, with a valid/ready handshake and a single global stall.
module pipelined_cla_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NGRP = WIDTH / 4;

    // x carries resolved sum bits below the current group and untouched A bits above it;
    // y carries the effective addend (B or ~B), so the mode is baked into the data at entry.
    logic [WIDTH-1:0] x_q [NGRP];
    logic [WIDTH-1:0] y_q [NGRP];
    logic [WIDTH-1:0] x_d [NGRP];
    logic [WIDTH-1:0] y_d [NGRP];
    logic [NGRP-1:0]  c_q, c_d, v_q, v_d;
    logic [WIDTH-1:0] xi, yi;
    logic             ci;
    logic [3:0]       g, p;
    logic [4:0]       c;
    logic             ovf_d, zero_d, ovf_q, zero_q, adv;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = rst_n && adv;
    assign out_valid = v_q[NGRP-1];
    assign Sum       = x_q[NGRP-1];
    assign Cout      = c_q[NGRP-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        c_d = c_q;
        v_d = v_q;
        xi  = '0;
        yi  = '0;
        ci  = 1'b0;
        g   = '0;
        p   = '0;
        c   = '0;
        for (int k = 0; k < NGRP; k++) begin
            xi = (k == 0) ? A : x_q[(k == 0) ? 0 : k - 1];
            yi = (k == 0) ? (sub ? ~B : B) : y_q[(k == 0) ? 0 : k - 1];
            ci = (k == 0) ? (sub | Cin) : c_q[(k == 0) ? 0 : k - 1];
            v_d[k] = (k == 0) ? in_valid : v_q[(k == 0) ? 0 : k - 1];
            g = xi[4*k +: 4] & yi[4*k +: 4];
            p = xi[4*k +: 4] ^ yi[4*k +: 4];
            c[0] = ci;
            c[1] = g[0] | (p[0] & ci);
            c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
            c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
            c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & ci);
            x_d[k] = xi;
            x_d[k][4*k +: 4] = p ^ c[3:0];
            y_d[k] = yi;
            c_d[k] = c[4];
        end
        // xi/yi still hold the last stage's inputs, whose MSBs are the original operand signs
        ovf_d  = (xi[WIDTH-1] == yi[WIDTH-1]) && (x_d[NGRP-1][WIDTH-1] != xi[WIDTH-1]);
        zero_d = ~|x_d[NGRP-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '{default: '0};
            y_q    <= '{default: '0};
            c_q    <= '0;
            v_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            x_q    <= x_d;
            y_q    <= y_d;
            c_q    <= c_d;
            v_q    <= v_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: directed and random add/sub traffic against an arithmetic model,
// with stalls, random back-pressure and mid-stream reset.
module tb_pipelined_cla_adder;
    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, Cin = 1'b0, sub = 1'b0, out_ready = 1'b1;
    logic         in_ready, out_valid, Cout, ovf, zero;
    logic [W-1:0] A = '0, B = '0, Sum;
    int           compared = 0, mismatched = 0;
    bit           rand_bp = 1'b0;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
    } res_t;
    res_t q[$];

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout), .ovf(ovf), .zero(zero)
    );

    // Reference: plain unsigned/signed integer arithmetic
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic sb);
        res_t e;
        int   sa, sv, r;
        sa = $signed(a);
        sv = $signed(b);
        if (sb) begin
            e.s = a - b;
            e.c = (a >= b);
            r   = sa - sv;
        end else begin
            e.s = a + b + W'(ci);
            e.c = (32'(a) + 32'(b) + 32'(ci)) > 32'h0000FFFF;
            r   = sa + sv + int'(ci);
        end
        e.v = (r > 32767) || (r < -32768);
        e.z = (e.s == '0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) q.push_back(model(A, B, Cin, sub));
            if (out_valid && out_ready) begin
                compared++;
                assert (q.size() != 0) else begin
                    mismatched++;
                    $error("FAIL extra_result: observed Sum=%h with no pending op, expected none", Sum);
                end
                if (q.size() != 0) begin
                    res_t e;
                    e = q.pop_front();
                    chk("sum", Sum, e.s);
                    chk("cout", Cout, e.c);
                    chk("ovf", ovf, e.v);
                    chk("zero", zero, e.z);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sb);
        logic acc;
        int   n;
        n = 0;
        A = a; B = b; Cin = ci; sub = sb; in_valid = 1'b1;
        do begin
            acc = in_ready;
            step();
            n++;
        end while (!acc && n < 100);
        chk("accept", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while (q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        chk("drain_pending", q.size(), 0);
    endtask

    initial begin
        logic [W-1:0] hs;
        logic [2:0]   hf;
        int           cnt;
        // reset state
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_sum", Sum, 0);
        chk("rst_flags", {Cout, ovf, zero}, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1 chk("ready_after_rst", in_ready, 1);

        // single add, latency
        op(16'h0006, 16'h0004, 1'b0, 1'b0);
        cnt = 1;
        while (!out_valid && cnt < 20) begin
            step();
            cnt++;
        end
        chk("latency", cnt, N);
        chk("add_sum", Sum, 16'h000A);
        chk("add_flags", {Cout, ovf, zero}, 3'b000);
        drain();

        // wrap, carry-in, overflow, subtract (back to back, mixed modes)
        op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        op(16'h0005, 16'h0009, 1'b1, 1'b0);
        op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        op(16'h8000, 16'h0001, 1'b0, 1'b1);
        op(16'h0005, 16'h0009, 1'b1, 1'b1);
        op(16'h0000, 16'h0000, 1'b0, 1'b1);
        drain();

        // stall mid-stream
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                out_ready = 1'b0;
                chk("stall_valid_before", out_valid, 1);
                hs = Sum;
                hf = {Cout, ovf, zero};
                repeat (3) begin
                    step();
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_valid", out_valid, 1);
                    chk("stall_sum_hold", Sum, hs);
                    chk("stall_flag_hold", {Cout, ovf, zero}, hf);
                end
                out_ready = 1'b1;
            end
            op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        drain();

        // random traffic under random back-pressure
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        drain();
        rand_bp = 1'b0;
        out_ready = 1'b1;

        // reset with operations in flight
        op(16'h1111, 16'h2222, 1'b0, 1'b0);
        op(16'h3333, 16'h4444, 1'b0, 1'b0);
        op(16'h5555, 16'h6666, 1'b0, 1'b1);
        op(16'h7777, 16'h0100, 1'b1, 1'b0);
        chk("inflight_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_sum", Sum, 0);
        q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        op(16'h0ABC, 16'h0001, 1'b0, 1'b0);
        op(16'h0010, 16'h0020, 1'b0, 1'b1);
        drain();
        repeat (N + 2) step();
        chk("idle_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
